// File: rtl/approx_mul_err_sweep.sv
// approx_mul_err_sweep: drives an approximate multiplier with every operand pair, checks each
// returned product against the exact one and accumulates ER/MED/WCE style statistics.
module approx_mul_err_sweep #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MUL_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH-1:0]   approx_prod,
    output logic                 busy,
    output logic                 done,
    output logic                 results_valid,
    output logic [2*WIDTH:0]     err_cnt,
    output logic [4*WIDTH-1:0]   sum_ed,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [WIDTH-1:0]     worst_a,
    output logic [WIDTH-1:0]     worst_b
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = (MUL_LAT > 1) ? CW'(MUL_LAT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e           state;
    logic [CW-1:0]    drain_cnt;

    logic             in_sweep;
    logic             in_run;
    logic             last_pair;
    logic             flush;
    logic             s_valid;
    logic [WIDTH-1:0] s_a;
    logic [WIDTH-1:0] s_b;
    logic [PW-1:0]    exact;
    logic [PW-1:0]    ed;
    logic             eval;

    assign in_sweep  = (state == StSweep);
    assign in_run    = in_sweep || (state == StDrain);
    assign last_pair = (&op_a) && (&op_b);
    assign flush     = in_run && abort;

    // Operand tags travel alongside the multiplier so each product meets its own pair
    generate
        if (MUL_LAT == 0) begin : g_comb
            assign s_valid = in_sweep;
            assign s_a     = op_a;
            assign s_b     = op_b;
        end else begin : g_pipe
            logic [MUL_LAT-1:0] tag_v;
            logic [WIDTH-1:0]   tag_a [MUL_LAT];
            logic [WIDTH-1:0]   tag_b [MUL_LAT];

            // Shift issued pairs down the tag chain; abort drops everything in flight
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    tag_v <= '0;
                    for (int i = 0; i < int'(MUL_LAT); i++) begin
                        tag_a[i] <= '0;
                        tag_b[i] <= '0;
                    end
                end else begin
                    tag_v[0] <= in_sweep;
                    tag_a[0] <= op_a;
                    tag_b[0] <= op_b;
                    for (int i = 1; i < int'(MUL_LAT); i++) begin
                        tag_v[i] <= tag_v[i-1];
                        tag_a[i] <= tag_a[i-1];
                        tag_b[i] <= tag_b[i-1];
                    end
                end
            end

            assign s_valid = tag_v[MUL_LAT-1];
            assign s_a     = tag_a[MUL_LAT-1];
            assign s_b     = tag_b[MUL_LAT-1];
        end
    endgenerate

    assign exact = {{WIDTH{1'b0}}, s_a} * {{WIDTH{1'b0}}, s_b};
    // Absolute difference without wrap
    assign ed    = (approx_prod >= exact) ? (approx_prod - exact) : (exact - approx_prod);
    assign eval  = s_valid && in_run && !abort;

    // Sweep FSM, operand generator and error accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            drain_cnt     <= '0;
            op_a          <= '0;
            op_b          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            results_valid <= 1'b0;
            err_cnt       <= '0;
            sum_ed        <= '0;
            max_ed        <= '0;
            worst_a       <= '0;
            worst_b       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state         <= StSweep;
                        busy          <= 1'b1;
                        op_a          <= '0;
                        op_b          <= '0;
                        results_valid <= 1'b0;
                        err_cnt       <= '0;
                        sum_ed        <= '0;
                        max_ed        <= '0;
                        worst_a       <= '0;
                        worst_b       <= '0;
                    end
                end
                StSweep: begin
                    if (abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (last_pair) begin
                        // Operands stay at the last pair once issuing stops
                        if (MUL_LAT == 0) begin
                            state         <= StDone;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            results_valid <= 1'b1;
                        end else begin
                            state     <= StDrain;
                            drain_cnt <= '0;
                        end
                    end else begin
                        op_b <= op_b + 1'b1;
                        if (&op_b) begin
                            op_a <= op_a + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state         <= StDone;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        results_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            if (eval) begin
                err_cnt <= err_cnt + {{PW{1'b0}}, (ed != '0)};
                sum_ed  <= sum_ed + {{PW{1'b0}}, ed};
                // Strict compare keeps the earliest pair on ties
                if (ed > max_ed) begin
                    max_ed  <= ed;
                    worst_a <= s_a;
                    worst_b <= s_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// tb_approx_mul_err_sweep: table-driven sweeps on 4-bit instances (latency 0 and 2) with a
// reference model and scoreboard queue, plus abort/reset sequences and one full 8-bit sweep.
module tb_approx_mul_err_sweep;

    typedef struct {
        int mode;
        bit with_abort;
        bit poke;
        int err;
        int sum;
        int mx;
        int wa;
        int wb;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic rst8 = 1'b1, start8 = 1'b0, abort8 = 1'b0;
    int   mode = 0;

    logic [3:0]  op_a0, op_b0, wa0, wb0, op_a2, op_b2, wa2, wb2;
    logic [7:0]  prod0, prod2, max0, max2, p1, p2;
    logic [8:0]  err0, err2;
    logic [15:0] sum0, sum2;
    logic        busy0, done0, rv0, busy2, done2, rv2;

    logic [7:0]  op_a8, op_b8, wa8, wb8;
    logic [15:0] prod8, max8;
    logic [16:0] err8;
    logic [31:0] sum8;
    logic        busy8, done8, rv8;

    int total = 0;
    int bad = 0;
    rec_t tbl[5];
    rec_t sb[$];

    function automatic logic [7:0] model4(input int m, input logic [3:0] a, input logic [3:0] b);
        int e;
        int r;
        e = int'(a) * int'(b);
        case (m)
            0: r = e;
            1: r = e + 1;
            2: r = 0;
            3: r = e & ~3;
            default: r = ((int'(a) + int'(b)) % 2 == 1) ? e + int'(a ^ b) : e - int'(a & b);
        endcase
        return 8'(r);
    endfunction

    function automatic rec_t ref_sweep(input int m);
        rec_t r;
        int p, ex, ed;
        r = '{default: 0};
        r.mode = m;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                p  = int'(model4(m, 4'(a), 4'(b)));
                ex = a * b;
                ed = (p >= ex) ? p - ex : ex - p;
                if (ed != 0) r.err++;
                r.sum += ed;
                if (ed > r.mx) begin
                    r.mx = ed;
                    r.wa = a;
                    r.wb = b;
                end
            end
        end
        return r;
    endfunction

    always_comb prod0 = model4(mode, op_a0, op_b0);

    always @(posedge clk) begin
        p1 <= model4(mode, op_a2, op_b2);
        p2 <= p1;
    end
    assign prod2 = p2;
    assign prod8 = '0;

    approx_mul_err_sweep #(.WIDTH(4), .MUL_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(op_a0), .op_b(op_b0), .approx_prod(prod0),
        .busy(busy0), .done(done0), .results_valid(rv0),
        .err_cnt(err0), .sum_ed(sum0), .max_ed(max0), .worst_a(wa0), .worst_b(wb0)
    );

    approx_mul_err_sweep #(.WIDTH(4), .MUL_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(op_a2), .op_b(op_b2), .approx_prod(prod2),
        .busy(busy2), .done(done2), .results_valid(rv2),
        .err_cnt(err2), .sum_ed(sum2), .max_ed(max2), .worst_a(wa2), .worst_b(wb2)
    );

    approx_mul_err_sweep #(.WIDTH(8), .MUL_LAT(0)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .abort(abort8),
        .op_a(op_a8), .op_b(op_b8), .approx_prod(prod8),
        .busy(busy8), .done(done8), .results_valid(rv8),
        .err_cnt(err8), .sum_ed(sum8), .max_ed(max8), .worst_a(wa8), .worst_b(wb8)
    );

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_res(input string tag, input rec_t e, input int err, input int sum,
                           input int mx, input int wa, input int wb, input int rv);
        chk({tag, "_err_cnt"}, err, e.err);
        chk({tag, "_sum_ed"}, sum, e.sum);
        chk({tag, "_max_ed"}, mx, e.mx);
        chk({tag, "_worst_a"}, wa, e.wa);
        chk({tag, "_worst_b"}, wb, e.wb);
        chk({tag, "_results_valid"}, rv, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {busy0, busy2}, 0);
        chk({tag, "_done"}, {done0, done2}, 0);
        chk({tag, "_rv"}, {rv0, rv2}, 0);
        chk({tag, "_ops"}, {op_a0, op_b0, op_a2, op_b2}, 0);
        chk({tag, "_err"}, {err0, err2}, 0);
        chk({tag, "_sum"}, {sum0, sum2}, 0);
        chk({tag, "_max"}, {max0, max2}, 0);
        chk({tag, "_worst"}, {wa0, wb0, wa2, wb2}, 0);
    endtask

    task automatic do_sweep(input rec_t r);
        rec_t e;
        int nb0, nb2, nd0, nd2;
        nb0 = 0; nb2 = 0; nd0 = 0; nd2 = 0;
        mode = r.mode;
        sb.push_back(r);
        start = 1'b1;
        abort = r.with_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 300; c++) begin
            nb0 += int'(busy0);
            nb2 += int'(busy2);
            nd0 += int'(done0);
            nd2 += int'(done2);
            start = r.poke && (c == 20 || c == 200);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("sb_pending", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_res("lat0", e, int'(err0), int'(sum0), int'(max0), int'(wa0), int'(wb0),
                    int'(rv0));
            chk_res("lat2", e, int'(err2), int'(sum2), int'(max2), int'(wa2), int'(wb2),
                    int'(rv2));
        end
        chk("busy_cycles_lat0", nb0, 256);
        chk("busy_cycles_lat2", nb2, 258);
        chk("done_pulses_lat0", nd0, 1);
        chk("done_pulses_lat2", nd2, 1);
        chk("op_hold", {op_a0, op_b0, op_a2, op_b2}, 16'hffff);
    endtask

    initial begin
        int nd, nb;
        rec_t r;
        bit seen;

        tbl[0] = '{mode: 0, with_abort: 0, poke: 0, err: 0, sum: 0, mx: 0, wa: 0, wb: 0};
        tbl[1] = '{mode: 1, with_abort: 0, poke: 0, err: 256, sum: 256, mx: 1, wa: 0, wb: 0};
        tbl[2] = '{mode: 2, with_abort: 0, poke: 0, err: 225, sum: 14400, mx: 225, wa: 15, wb: 15};
        tbl[3] = ref_sweep(3);
        tbl[3].poke = 1'b1;
        tbl[4] = ref_sweep(4);
        tbl[4].with_abort = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        rst8 = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_sweep(tbl[i]);
        end

        // Abort mid-sweep: no done, results stay invalid, later sweep is clean
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", {busy0, busy2}, 0);
        chk("abort_rv", {rv0, rv2}, 0);
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            nd += int'(done0) + int'(done2);
            @(posedge clk); #1;
        end
        chk("abort_no_done", nd, 0);
        do_sweep(tbl[0]);

        // Reset mid-sweep with errors already accumulated
        mode = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("pre_rst_accum", (err0 != 0 && err2 != 0), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("midrst");
        r = tbl[4];
        r.with_abort = 1'b0;
        do_sweep(r);

        // Full 8-bit sweep against an all-zero multiplier
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        nb = 0;
        seen = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            nb += int'(busy8);
            if (done8) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("w8_done_seen", seen, 1);
        chk("w8_busy_cycles", nb, 65536);
        chk("w8_err_cnt", err8, 65025);
        chk("w8_sum_ed", sum8, 1065369600);
        chk("w8_max_ed", max8, 65025);
        chk("w8_worst", {wa8, wb8}, 16'hffff);
        chk("w8_rv", rv8, 1);
        @(posedge clk); #1;
        chk("w8_done_single", done8, 0);
        chk("w8_rv_hold", rv8, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
